mem_arbiter: RTL and testbench

//   Shares the single core memory port between two requesters: the core
//   (decoder-driven fetch/read/write stream) and the program loader/debug

---
 rtl/mem_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester arbiter for the core memory port
// Core vs loader/debug port: round-robin when unlocked, locked loader bursts with a forced core slot.
`ifndef MEM_PAUSE
`define MEM_PAUSE 2'b00
`endif
`ifndef MEM_READ
`define MEM_READ 2'b01
`endif
`ifndef MEM_WRITE
`define MEM_WRITE 2'b10
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module mem_arbiter #(
   parameter int DATA_W    = `DATA_WIDTH,
   parameter int ADDR_W    = 8,
   parameter int MAX_BURST = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_core_req,
   input  logic [1:0]        i_core_action,
   input  logic [ADDR_W-1:0] i_core_addr,
   input  logic [DATA_W-1:0] i_core_wdata,
   output logic              o_core_gnt,
   output logic              o_core_rvalid,
   output logic [DATA_W-1:0] o_core_rdata,
   input  logic              i_ldr_req,
   input  logic              i_ldr_lock,
   input  logic [1:0]        i_ldr_action,
   input  logic [ADDR_W-1:0] i_ldr_addr,
   input  logic [DATA_W-1:0] i_ldr_wdata,
   output logic              o_ldr_gnt,
   output logic              o_ldr_rvalid,
   output logic [DATA_W-1:0] o_ldr_rdata,
   output logic [1:0]        o_mem_action,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   input  logic [DATA_W-1:0] i_mem_rdata
);

   localparam int CNT_W = $clog2(MAX_BURST + 1);

   typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             last_ldr_q, last_ldr_d;
   logic             core_rvalid_q, ldr_rvalid_q;
   logic             core_valid, ldr_valid, burst_full;

   assign core_valid = i_core_req && (i_core_action == `MEM_READ || i_core_action == `MEM_WRITE);
   assign ldr_valid  = i_ldr_req  && (i_ldr_action  == `MEM_READ || i_ldr_action  == `MEM_WRITE);
   assign burst_full = (count_q == CNT_W'(MAX_BURST));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= UNLOCKED;
         count_q       <= '0;
         last_ldr_q    <= 1'b1;
         core_rvalid_q <= 1'b0;
         ldr_rvalid_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         count_q       <= count_d;
         last_ldr_q    <= last_ldr_d;
         core_rvalid_q <= o_core_gnt && (i_core_action == `MEM_READ);
         ldr_rvalid_q  <= o_ldr_gnt  && (i_ldr_action  == `MEM_READ);
      end
   end

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      last_ldr_d = last_ldr_q;
      if (o_core_gnt)
         last_ldr_d = 1'b0;
      else if (o_ldr_gnt)
         last_ldr_d = 1'b1;
      case (state_q)
         UNLOCKED: begin
            if (o_ldr_gnt && i_ldr_lock) begin
               state_d = LOCKED;
               count_d = CNT_W'(1);
            end
         end
         LOCKED: begin
            // A loader that stops requesting releases the lock in that same cycle.
            if (!ldr_valid) begin
               state_d = UNLOCKED;
               count_d = '0;
            end else if (o_core_gnt) begin
               count_d = '0;
            end else if (!i_ldr_lock) begin
               state_d = UNLOCKED;
               count_d = '0;
            end else if (!burst_full) begin
               count_d = count_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = UNLOCKED;
            count_d = '0;
         end
      endcase
   end

   always_comb begin
      o_core_gnt   = 1'b0;
      o_ldr_gnt    = 1'b0;
      o_mem_action = `MEM_PAUSE;
      o_mem_addr   = '0;
      o_mem_wdata  = '0;
      if (rst_n) begin
         if (state_q == LOCKED) begin
            // Saturated burst count holds until the core is actually waiting.
            if (burst_full && core_valid)
               o_core_gnt = 1'b1;
            else if (ldr_valid)
               o_ldr_gnt = 1'b1;
            else if (core_valid)
               o_core_gnt = 1'b1;
         end else if (core_valid && ldr_valid) begin
            o_core_gnt = last_ldr_q;
            o_ldr_gnt  = !last_ldr_q;
         end else begin
            o_core_gnt = core_valid;
            o_ldr_gnt  = ldr_valid;
         end
      end
      if (o_core_gnt) begin
         o_mem_action = i_core_action;
         o_mem_addr   = i_core_addr;
         o_mem_wdata  = i_core_wdata;
      end else if (o_ldr_gnt) begin
         o_mem_action = i_ldr_action;
         o_mem_addr   = i_ldr_addr;
         o_mem_wdata  = i_ldr_wdata;
      end
   end

   assign o_core_rvalid = core_rvalid_q && rst_n;
   assign o_ldr_rvalid  = ldr_rvalid_q  && rst_n;
   assign o_core_rdata  = i_mem_rdata;
   assign o_ldr_rdata   = i_mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
// Requester queues feed the DUT; a transaction-level model predicts every cycle.
`ifndef MEM_PAUSE
`define MEM_PAUSE 2'b00
`endif
`ifndef MEM_READ
`define MEM_READ 2'b01
`endif
`ifndef MEM_WRITE
`define MEM_WRITE 2'b10
`endif

module tb_mem_arbiter;

   localparam int MAXB = 8;

   typedef struct packed {
      logic [1:0] act;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic       lock;
   } txn_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       core_req, ldr_req, ldr_lock;
   logic [1:0] core_action, ldr_action;
   logic [7:0] core_addr, core_wdata, ldr_addr, ldr_wdata, mem_rdata;
   logic       core_gnt, core_rvalid, ldr_gnt, ldr_rvalid;
   logic [7:0] core_rdata, ldr_rdata, mem_addr, mem_wdata;
   logic [1:0] mem_action;

   txn_t core_q[$];
   txn_t ldr_q[$];
   bit   core_ovr = 1'b0;

   int   n_checks = 0;
   int   n_fail   = 0;

   int         m_locked   = 0;
   int         m_count    = 0;
   bit         m_last_ldr = 1'b1;
   int         m_pend     = 0;
   logic [7:0] m_pend_data = 8'h00;
   logic [7:0] nxt_rdata  = 8'hEE;

   logic [7:0] q_cg[$], q_lg[$], q_crv[$], q_lrv[$], q_crd[$], q_act[$];

   always #5 clk = ~clk;

   mem_arbiter #(.DATA_W(8), .ADDR_W(8), .MAX_BURST(MAXB)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_core_req(core_req), .i_core_action(core_action), .i_core_addr(core_addr),
      .i_core_wdata(core_wdata), .o_core_gnt(core_gnt), .o_core_rvalid(core_rvalid),
      .o_core_rdata(core_rdata),
      .i_ldr_req(ldr_req), .i_ldr_lock(ldr_lock), .i_ldr_action(ldr_action),
      .i_ldr_addr(ldr_addr), .i_ldr_wdata(ldr_wdata), .o_ldr_gnt(ldr_gnt),
      .o_ldr_rvalid(ldr_rvalid), .o_ldr_rdata(ldr_rdata),
      .o_mem_action(mem_action), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
      .i_mem_rdata(mem_rdata)
   );

   function automatic logic [7:0] mem_fn(logic [7:0] a);
      return a ^ 8'hB5;
   endfunction

   function automatic txn_t mk(logic [1:0] a, logic [7:0] ad, logic [7:0] wd, logic lk);
      txn_t t;
      t.act = a; t.addr = ad; t.wdata = wd; t.lock = lk;
      return t;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive();
      if (core_ovr) begin
         core_req = 1'b1; core_action = `MEM_PAUSE; core_addr = 8'h55; core_wdata = 8'h00;
      end else if (core_q.size() > 0) begin
         core_req = 1'b1; core_action = core_q[0].act;
         core_addr = core_q[0].addr; core_wdata = core_q[0].wdata;
      end else begin
         core_req = 1'b0; core_action = `MEM_PAUSE; core_addr = 8'h00; core_wdata = 8'h00;
      end
      if (ldr_q.size() > 0) begin
         ldr_req = 1'b1; ldr_action = ldr_q[0].act; ldr_lock = ldr_q[0].lock;
         ldr_addr = ldr_q[0].addr; ldr_wdata = ldr_q[0].wdata;
      end else begin
         ldr_req = 1'b0; ldr_action = `MEM_PAUSE; ldr_lock = 1'b0;
         ldr_addr = 8'h00; ldr_wdata = 8'h00;
      end
      mem_rdata = nxt_rdata;
   endtask

   task automatic cycle();
      drive();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      q_cg.delete(); q_lg.delete(); q_crv.delete(); q_lrv.delete(); q_crd.delete(); q_act.delete();
   endtask

   // Model: who should own the port this cycle, then what the memory and returns look like.
   always @(negedge clk) begin : cmp
      bit         cv, lv;
      int         win;
      logic [1:0] e_act;
      logic [7:0] e_addr, e_wd;
      cv  = core_req && (core_action == `MEM_READ || core_action == `MEM_WRITE);
      lv  = ldr_req  && (ldr_action  == `MEM_READ || ldr_action  == `MEM_WRITE);
      win = 0;
      if (rst_n) begin
         if (m_locked != 0)
            win = (cv && m_count >= MAXB) ? 1 : (lv ? 2 : (cv ? 1 : 0));
         else if (cv && lv)
            win = m_last_ldr ? 1 : 2;
         else
            win = cv ? 1 : (lv ? 2 : 0);
      end
      e_act  = (win == 1) ? core_action : (win == 2) ? ldr_action : `MEM_PAUSE;
      e_addr = (win == 1) ? core_addr   : (win == 2) ? ldr_addr   : 8'h00;
      e_wd   = (win == 1) ? core_wdata  : (win == 2) ? ldr_wdata  : 8'h00;

      chk("core_gnt", {31'd0, core_gnt}, {31'd0, win == 1});
      chk("ldr_gnt", {31'd0, ldr_gnt}, {31'd0, win == 2});
      chk("mem_action", {30'd0, mem_action}, {30'd0, e_act});
      chk("mem_addr", {24'd0, mem_addr}, {24'd0, e_addr});
      chk("mem_wdata", {24'd0, mem_wdata}, {24'd0, e_wd});
      chk("core_rvalid", {31'd0, core_rvalid}, {31'd0, rst_n && m_pend == 1});
      chk("ldr_rvalid", {31'd0, ldr_rvalid}, {31'd0, rst_n && m_pend == 2});
      chk("rvalid_excl", {31'd0, core_rvalid && ldr_rvalid}, 32'd0);
      if (rst_n && m_pend == 1) chk("core_rdata", {24'd0, core_rdata}, {24'd0, m_pend_data});
      if (rst_n && m_pend == 2) chk("ldr_rdata", {24'd0, ldr_rdata}, {24'd0, m_pend_data});

      q_cg.push_back({7'd0, core_gnt});
      q_lg.push_back({7'd0, ldr_gnt});
      q_crv.push_back({7'd0, core_rvalid});
      q_lrv.push_back({7'd0, ldr_rvalid});
      q_crd.push_back(core_rdata);
      q_act.push_back({6'd0, mem_action});

      if (!rst_n) begin
         m_locked = 0; m_count = 0; m_last_ldr = 1'b1; m_pend = 0; nxt_rdata = 8'hEE;
      end else begin
         m_pend      = (win != 0 && e_act == `MEM_READ) ? win : 0;
         m_pend_data = mem_fn(e_addr);
         nxt_rdata   = (m_pend != 0) ? mem_fn(e_addr) : 8'hEE;
         if (win != 0) m_last_ldr = (win == 2);
         if (m_locked != 0) begin
            if (!lv) begin
               m_locked = 0; m_count = 0;
            end else if (win == 1) begin
               m_count = 0;
            end else if (!ldr_lock) begin
               m_locked = 0; m_count = 0;
            end else begin
               m_count = (m_count + 1 > MAXB) ? MAXB : m_count + 1;
            end
         end else if (win == 2 && ldr_lock) begin
            m_locked = 1; m_count = 1;
         end
         if (win == 1) void'(core_q.pop_front());
         if (win == 2) void'(ldr_q.pop_front());
      end
   end

   initial begin
      string pat;
      rst_n = 1'b0;
      drive();
      @(posedge clk);
      #1;

      // Reset state, then a single core read.
      clear_logs();
      cycle(); cycle();
      chk("rst_core_gnt", {24'd0, q_cg[0]}, 32'd0);
      chk("rst_ldr_gnt", {24'd0, q_lg[0]}, 32'd0);
      chk("rst_mem_action", {24'd0, q_act[1]}, {30'd0, `MEM_PAUSE});
      rst_n = 1'b1;
      clear_logs();
      core_q.push_back(mk(`MEM_READ, 8'h10, 8'h00, 1'b0));
      cycle(); cycle(); cycle();
      chk("t1_gnt0", {24'd0, q_cg[0]}, 32'd1);
      chk("t1_rvalid0", {24'd0, q_crv[0]}, 32'd0);
      chk("t1_rvalid1", {24'd0, q_crv[1]}, 32'd1);
      chk("t1_rdata1", {24'd0, q_crd[1]}, 32'hA5);
      chk("t1_rvalid2", {24'd0, q_crv[2]}, 32'd0);

      // Both request reads straight out of reset: strict alternation.
      rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
      clear_logs();
      core_q.push_back(mk(`MEM_READ, 8'h20, 8'h00, 1'b0));
      core_q.push_back(mk(`MEM_READ, 8'h21, 8'h00, 1'b0));
      ldr_q.push_back(mk(`MEM_READ, 8'h30, 8'h00, 1'b0));
      ldr_q.push_back(mk(`MEM_READ, 8'h31, 8'h00, 1'b0));
      for (int i = 0; i < 6; i++) cycle();
      pat = "CLCL";
      for (int i = 0; i < 4; i++) begin
         chk("t2_core_gnt", {24'd0, q_cg[i]}, {31'd0, pat[i] == "C"});
         chk("t2_ldr_gnt", {24'd0, q_lg[i]}, {31'd0, pat[i] == "L"});
         chk("t2_core_rv", {24'd0, q_crv[i+1]}, {31'd0, pat[i] == "C"});
         chk("t2_ldr_rv", {24'd0, q_lrv[i+1]}, {31'd0, pat[i] == "L"});
      end

      // Locked write burst of 12 with the core requesting throughout.
      clear_logs();
      for (int i = 0; i < 3; i++) core_q.push_back(mk(`MEM_WRITE, 8'h40 + 8'(i), 8'h90 + 8'(i), 1'b0));
      for (int i = 0; i < 12; i++) ldr_q.push_back(mk(`MEM_WRITE, 8'h80 + 8'(i), 8'hC0 + 8'(i), i != 11));
      for (int i = 0; i < 16; i++) cycle();
      pat = "CLLLLLLLLCLLLLC";
      for (int i = 0; i < 15; i++) begin
         chk("t3_core_gnt", {24'd0, q_cg[i]}, {31'd0, pat[i] == "C"});
         chk("t3_ldr_gnt", {24'd0, q_lg[i]}, {31'd0, pat[i] == "L"});
      end

      // Loader locks, then drops req while the core waits.
      clear_logs();
      ldr_q.push_back(mk(`MEM_WRITE, 8'hA0, 8'h11, 1'b1));
      core_q.push_back(mk(`MEM_READ, 8'hA1, 8'h00, 1'b0));
      cycle(); cycle(); cycle();
      chk("t4_ldr_gnt0", {24'd0, q_lg[0]}, 32'd1);
      chk("t4_core_gnt1", {24'd0, q_cg[1]}, 32'd1);

      // Core asserts req with a pause action: not a request.
      clear_logs();
      core_ovr = 1'b1;
      cycle(); cycle(); cycle();
      core_ovr = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("t5_core_gnt", {24'd0, q_cg[i]}, 32'd0);
         chk("t5_mem_action", {24'd0, q_act[i]}, {30'd0, `MEM_PAUSE});
      end

      // Reset right after a locked loader read grant.
      clear_logs();
      for (int i = 0; i < 3; i++) ldr_q.push_back(mk(`MEM_READ, 8'h60 + 8'(i), 8'h00, 1'b1));
      core_q.push_back(mk(`MEM_READ, 8'h70, 8'h00, 1'b0));
      cycle(); cycle();
      rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
      cycle(); cycle(); cycle();
      chk("t6_ldr_gnt1", {24'd0, q_lg[1]}, 32'd1);
      chk("t6_ldr_rvalid_rst", {24'd0, q_lrv[2]}, 32'd0);
      chk("t6_no_gnt_rst", {24'd0, q_cg[2] | q_lg[2]}, 32'd0);
      chk("t6_core_after_rst", {24'd0, q_cg[3]}, 32'd1);
      chk("t6_core_rvalid", {24'd0, q_crv[4]}, 32'd1);
      chk("t6_core_rdata", {24'd0, q_crd[4]}, 32'h70 ^ 32'hB5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
